perf_event_counters: RTL and testbench

PERF_EVENT_COUNTERS -- requirements
Module: perf_event_counters

---
 rtl/perf_event_counters.sv | 128 ++++++++++++
 tb/tb_perf_event_counters.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/perf_event_counters.sv
// Per-channel performance event counters with a run-cycle watchdog.
// Counting runs between an enable and a halt/timeout; clr or rst_n re-arms.
module perf_event_counters #(
  parameter int unsigned NUM_CH      = 5,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SAT_MODE    = 0,
  parameter int unsigned CYCLE_LIMIT = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              halt,
  input  logic [NUM_CH-1:0] ev,
  input  logic [3:0]        rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [NUM_CH-1:0] ovf,
  output logic              halted,
  output logic              timeout
);

  localparam int unsigned    LIM_W    = 33;
  localparam logic [32:0]    LIMIT    = LIM_W'(CYCLE_LIMIT);
  localparam logic [CNT_W-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] WRAP_VAL = (SAT_MODE != 0) ? ALL_ONES : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALTED,
    S_TIMEOUT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt       [NUM_CH];
  logic [CNT_W-1:0]  cnt_nxt   [NUM_CH];
  logic [NUM_CH-1:0] ovf_nxt;
  logic [CNT_W-1:0]  cycle_nxt;
  logic [CNT_W-1:0]  rd_nxt;
  logic              halted_nxt;
  logic              timeout_nxt;
  logic              limit_hit;

  // Wide compare so the watchdog limit is never truncated to CNT_W
  assign limit_hit = ((LIM_W'(cycle_cnt) + LIM_W'(1)) == LIMIT);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; halt wins over the watchdog in the same cycle
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (en) state_nxt = S_RUN;
        S_RUN: begin
          if (halt)           state_nxt = S_HALTED;
          else if (limit_hit) state_nxt = S_TIMEOUT;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Output decode, registered alongside the state
  always_comb begin
    halted_nxt  = (state_nxt == S_HALTED);
    timeout_nxt = (state_nxt == S_TIMEOUT);
  end

  // Counter datapath: only RUN counts; all-ones increments wrap or saturate
  always_comb begin
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    cycle_nxt = cycle_cnt;
    if (clr) begin
      for (int unsigned i = 0; i < NUM_CH; i++) cnt_nxt[i] = '0;
      ovf_nxt   = '0;
      cycle_nxt = '0;
    end else if (state == S_RUN) begin
      cycle_nxt = (cycle_cnt == ALL_ONES) ? WRAP_VAL : cycle_cnt + CNT_W'(1);
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (ev[i]) begin
          if (cnt[i] == ALL_ONES) begin
            cnt_nxt[i] = WRAP_VAL;
            ovf_nxt[i] = 1'b1;
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Read mux looks at next counts so rd_data includes this edge's increment
  always_comb begin
    rd_nxt = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rd_sel == 4'(i)) rd_nxt = cnt_nxt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      ovf       <= '0;
      cycle_cnt <= '0;
      rd_data   <= '0;
      halted    <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      ovf       <= ovf_nxt;
      cycle_cnt <= cycle_nxt;
      rd_data   <= rd_nxt;
      halted    <= halted_nxt;
      timeout   <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_perf_event_counters.sv
// Directed bench for perf_event_counters: four parameterisations share one
// stimulus stream; each check targets the instance that scenario exercises.
module tb_perf_event_counters;

  logic       clk = 1'b0;
  logic       rst_n, en, clr, halt;
  logic [4:0] ev;
  logic [3:0] rd_sel;

  logic [31:0] def_rd, def_cyc, lim_rd, lim_cyc;
  logic [7:0]  w8_rd, w8_cyc, sat_rd, sat_cyc;
  logic [4:0]  def_ovf, w8_ovf, sat_ovf, lim_ovf;
  logic        def_halted, def_to, w8_halted, w8_to, sat_halted, sat_to, lim_halted, lim_to;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  perf_event_counters u_def (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .halt(halt), .ev(ev), .rd_sel(rd_sel),
    .rd_data(def_rd), .cycle_cnt(def_cyc), .ovf(def_ovf), .halted(def_halted), .timeout(def_to)
  );

  perf_event_counters #(.CNT_W(8), .SAT_MODE(0), .CYCLE_LIMIT(1000)) u_w8 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .halt(halt), .ev(ev), .rd_sel(rd_sel),
    .rd_data(w8_rd), .cycle_cnt(w8_cyc), .ovf(w8_ovf), .halted(w8_halted), .timeout(w8_to)
  );

  perf_event_counters #(.CNT_W(8), .SAT_MODE(1), .CYCLE_LIMIT(1000)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .halt(halt), .ev(ev), .rd_sel(rd_sel),
    .rd_data(sat_rd), .cycle_cnt(sat_cyc), .ovf(sat_ovf), .halted(sat_halted), .timeout(sat_to)
  );

  perf_event_counters #(.CYCLE_LIMIT(20)) u_lim (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .halt(halt), .ev(ev), .rd_sel(rd_sel),
    .rd_data(lim_rd), .cycle_cnt(lim_cyc), .ovf(lim_ovf), .halted(lim_halted), .timeout(lim_to)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; inputs driven and outputs sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_sweep [8];

  initial begin
    exp_sweep = '{11, 0, 11, 0, 0, 0, 0, 0};
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; halt = 1'b0; ev = '0; rd_sel = '0;
    step(); step();
    check("rst_cycle", def_cyc, 0);
    check("rst_rd", def_rd, 0);
    check("rst_halted", 32'(def_halted), 0);
    check("rst_timeout", 32'(def_to), 0);
    check("rst_ovf", 32'(def_ovf), 0);
    rst_n = 1'b1;

    // Events in IDLE must not count
    ev = '1;
    step(); step();
    check("idle_cycle", def_cyc, 0);
    check("idle_rd0", def_rd, 0);

    // Basic run: enable edge counts nothing, 10 event cycles, then halt cycle
    en = 1'b1; ev = '0;
    step();
    en = 1'b0; ev = 5'b00101;
    repeat (10) step();
    halt = 1'b1;
    step();
    halt = 1'b0; ev = '0;
    check("run_halted", 32'(def_halted), 1);
    check("run_timeout", 32'(def_to), 0);
    check("run_cycle", def_cyc, 11);
    check("run_ovf", 32'(def_ovf), 0);

    // HALTED ignores ev and halt
    ev = '1; halt = 1'b1;
    repeat (3) step();
    ev = '0; halt = 1'b0;
    check("halt_hold_cycle", def_cyc, 11);
    check("halt_hold_state", 32'(def_halted), 1);

    // Read sweep: value appears one cycle after its select
    for (int i = 0; i < 8; i++) begin
      rd_sel = 4'(i);
      if (i > 0) check($sformatf("sweep_lat%0d", i), def_rd, 32'(exp_sweep[i-1]));
      step();
      check($sformatf("sweep%0d", i), def_rd, 32'(exp_sweep[i]));
    end

    // Overflow/saturation on channel 1 and watchdog timing on u_lim
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_halted", 32'(def_halted), 0);
    check("clr_cycle", def_cyc, 0);
    rd_sel = 4'd1; en = 1'b1;
    step();
    en = 1'b0; ev = 5'b00010;
    for (int i = 0; i < 257; i++) begin
      step();
      if (i == 18) check("lim_pre_timeout", 32'(lim_to), 0);
      if (i == 19) begin
        check("lim_timeout", 32'(lim_to), 1);
        check("lim_cycle", lim_cyc, 20);
      end
      if (i == 24) check("lim_cycle_hold", lim_cyc, 20);
    end
    ev = '0;
    check("w8_rd", 32'(w8_rd), 1);
    check("w8_ovf", 32'(w8_ovf), 2);
    check("w8_cycle_wrap", 32'(w8_cyc), 1);
    check("sat_rd", 32'(sat_rd), 255);
    check("sat_ovf", 32'(sat_ovf), 2);
    check("sat_cycle", 32'(sat_cyc), 255);
    check("def_rd_257", def_rd, 257);
    check("def_ovf_none", 32'(def_ovf), 0);
    check("lim_rd_frozen", lim_rd, 20);
    check("lim_not_halted", 32'(lim_halted), 0);

    // Halt on the same cycle the watchdog limit is reached
    clr = 1'b1;
    step();
    clr = 1'b0; en = 1'b1;
    step();
    en = 1'b0;
    repeat (19) step();
    check("coll_pre_timeout", 32'(lim_to), 0);
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("coll_halted", 32'(lim_halted), 1);
    check("coll_timeout", 32'(lim_to), 0);
    check("coll_cycle", lim_cyc, 20);

    // clr with halt and en mid-RUN returns to IDLE
    clr = 1'b1;
    step();
    clr = 1'b0; en = 1'b1;
    step();
    en = 1'b0; ev = 5'b00101;
    repeat (3) step();
    rd_sel = 4'd0; clr = 1'b1; halt = 1'b1; en = 1'b1;
    step();
    clr = 1'b0; halt = 1'b0; en = 1'b0;
    check("clrhalt_halted", 32'(def_halted), 0);
    check("clrhalt_cycle", def_cyc, 0);
    check("clrhalt_rd", def_rd, 0);
    repeat (2) step();
    check("clrhalt_idle_rd", def_rd, 0);
    check("clrhalt_idle_cycle", def_cyc, 0);

    // Reset mid-RUN beats en/halt/clr/ev
    en = 1'b1;
    step();
    en = 1'b0;
    repeat (4) step();
    check("prereset_rd", def_rd, 4);
    rst_n = 1'b0; en = 1'b1; halt = 1'b1; clr = 1'b1;
    step();
    rst_n = 1'b1; en = 1'b0; halt = 1'b0; clr = 1'b0;
    check("midrst_cycle", def_cyc, 0);
    check("midrst_rd", def_rd, 0);
    check("midrst_halted", 32'(def_halted), 0);
    step();
    check("postrst_idle_cycle", def_cyc, 0);
    ev = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
